alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//  Parametrised, pipelined successor to the single-cycle alu: same 3-bit aluop set, generalised
//  data width and latency, plus valid/ready backpressure, an opaque tag, and a zero flag.
//  Sits between decode/issue and writeback in the execute path.
//  Accepts one op per cycle; results leave in order after LATENCY cycles when downstream is ready.
// PARAMETERS
//  WIDTH    32  operand/result width in bits, power of two, >= 8
//  LATENCY  2   pipeline register stages from accept to valid_o, >= 1
//  TAG_W    4   width of the sideband tag carried unchanged with each op
// PORTS
//  clk      in   1              clock, all state on rising edge
//  rst_n    in   1              asynchronous reset, active low
//  aluop    in   3              operation, alu_pkg::alu_op_t
//  a        in   WIDTH          operand A
//  b        in   WIDTH          operand B; shifts use b[$clog2(WIDTH)-1:0]
//  tag_i    in   TAG_W          sideband tag
//  valid_i  in   1              input op present
//  ready_o  out  1              pipe accepts an op this cycle
//  f        out  WIDTH          result
//  zero_o   out  1              f == 0
//  tag_o    out  TAG_W          tag of the op on f
//  valid_o  out  1              f/zero_o/tag_o valid
//  ready_i  in   1              downstream accepts result
// BEHAVIOUR
//  - Reset (async assert, sync release): every stage valid=0, data/tag=0; outputs 0, ready_o=1.
//  - Ops: 000 add, 001 sll, 010 sra, 011 sub, 100 xor, 101 srl, 110 or, 111 and; add/sub wrap
//    modulo 2^WIDTH; sra sign-fills from a[WIDTH-1]; shift amount 0 passes a unchanged.
//  - Result computed combinationally at entry, then carried through LATENCY registers.
//  - Accept: valid_i && ready_o. Deliver: valid_o && ready_i. Both may occur in one cycle.
//  - Stage k enable: en_k = ~v_k | en_(k+1); last stage en = ~valid_o | ready_i;
//    ready_o = en_0 (combinational from ready_i; no bubble cost, bubbles collapse).
//  - With ready_i held 1, accepted op appears on valid_o exactly LATENCY cycles later;
//    throughput 1 op/cycle.
//  - Stall: valid_o && !ready_i holds f/zero_o/tag_o/valid_o stable until delivered; upstream
//    stages fill, then ready_o drops. Max in flight = LATENCY.
//  - valid_i with ready_o=0: input ignored; sender holds it (no drop, no duplicate).
//  - Order strictly FIFO; tag_o always matches the op producing f.
//  - Reset mid-operation: all in-flight ops discarded, valid_o=0 same cycle rst_n falls.
//  - Data/tag of stages with v=0 are don't-care internally but outputs are 0 when valid_o=0.
// STRUCTURE
//  - alu_pkg: alu_op_t enum (8 codes above), ALU_OP_W=3 localparam.
//  - Sub-module alu_pipe_stage: one register slice (valid, data, tag) with enable/async clear;
//    alu_pipe instantiates LATENCY of them via generate plus the combinational op mux.
// TESTING (WIDTH=32, LATENCY=2, TAG_W=4)
//  - add a=0xFFFF_FFFF b=1 tag=3, ready_i=1 -> 2 cycles later f=0, zero_o=1, tag_o=3, valid_o=1.
//  - sra a=0x8000_0000 b=0x21 -> f=0xC000_0000 (amount 1); srl same -> 0x4000_0000; sll b=0 -> a.
//  - Back-to-back sub 5-3, xor 0xF0^0xFF, and 0xF0&0x0F every cycle -> f=2,0x0F,0 on
//    consecutive cycles, ready_o stays 1.
//  - ready_i=0 for 4 cycles while sending 4 ops -> valid_o held stable; ready_o=0 after 2
//    accepted; release -> the 2 accepted ops in order, tags intact, no loss/dup.
//  - Assert rst_n=0 with 2 ops in flight -> valid_o=0 immediately, f=0; after release ready_o=1,
//    no stale result.
//  - Random ops/operands/stalls vs golden model; cover all 8 ops x stall/no-stall x shift 0/31.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encoding for the pipelined execute ALU.
// The 3-bit code set matches the original single-cycle alu so decode
// logic upstream does not change.
package alu_pkg;

    localparam int ALU_OP_W = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SLL = 3'b001,
        ALU_SRA = 3'b010,
        ALU_SUB = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SRL = 3'b101,
        ALU_OR  = 3'b110,
        ALU_AND = 3'b111
    } alu_op_t;

    // True for the three shift codes, which only look at the low bits of b.
    function automatic logic isShiftOp(input alu_op_t op);
        return (op == ALU_SLL) || (op == ALU_SRA) || (op == ALU_SRL);
    endfunction

endpackage : alu_pkg

// File: rtl/alu_pipe_stage.sv
// alu_pipe_stage: one register slice of the ALU result pipe.
// Holds a valid bit, the result word and its sideband tag. When en_i is
// high the slice loads whatever the previous slice (or the op mux) offers,
// including a bubble; when low it holds. Async reset clears everything.
module alu_pipe_stage #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [TAG_W-1:0] tag_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [TAG_W-1:0] tag_q,   tag_d;

    // Next-state: load the upstream slot when enabled, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        tag_d   = tag_q;
        if (en_i) begin
            valid_d = valid_i;
            data_d  = data_i;
            tag_d   = tag_i;
        end
    end

    // Slice register with asynchronous clear so reset drops in-flight ops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign tag_o   = tag_q;

endmodule : alu_pipe_stage

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined execute ALU with valid/ready flow control.
// The result is computed combinationally when the op is accepted and then
// carried through LATENCY register slices. Each slice advances when it is
// empty or when the slice after it advances, so bubbles collapse and a
// stalled output backs the pipe up one slice at a time until ready_o drops.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ALU_OP_W-1:0] aluop,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [TAG_W-1:0]    tag_i,
    input  logic                valid_i,
    output logic                ready_o,
    output logic [WIDTH-1:0]    f,
    output logic                zero_o,
    output logic [TAG_W-1:0]    tag_o,
    output logic                valid_o,
    input  logic                ready_i
);

    localparam int SHW = $clog2(WIDTH);

    alu_op_t          op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] result;

    // Per-slice enables and the values each slice would load.
    logic [LATENCY-1:0] en;
    logic [LATENCY-1:0] vIn;
    logic [WIDTH-1:0]   dIn [LATENCY];
    logic [TAG_W-1:0]   tIn [LATENCY];

    // Per-slice registered contents.
    logic [LATENCY-1:0] vS;
    logic [WIDTH-1:0]   dS  [LATENCY];
    logic [TAG_W-1:0]   tS  [LATENCY];

    assign op    = alu_op_t'(aluop);
    assign shamt = b[SHW-1:0];

    // Operation mux; add/sub wrap naturally, sra fills with a's sign bit.
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SLL: result = a << shamt;
            ALU_SRA: result = $unsigned($signed(a) >>> shamt);
            ALU_SUB: result = a - b;
            ALU_XOR: result = a ^ b;
            ALU_SRL: result = a >> shamt;
            ALU_OR:  result = a | b;
            ALU_AND: result = a & b;
            default: result = '0;
        endcase
    end

    // Enable chain from the output backwards; the head frees when downstream takes it.
    always_comb begin
        en = '0;
        en[LATENCY-1] = ~vS[LATENCY-1] | ready_i;
        for (int k = LATENCY - 2; k >= 0; k--) begin
            en[k] = ~vS[k] | en[k+1];
        end
    end

    // Slice 0 is fed by the op mux; every later slice by its predecessor.
    always_comb begin
        vIn    = '0;
        vIn[0] = valid_i;
        dIn[0] = result;
        tIn[0] = tag_i;
        for (int k = 1; k < LATENCY; k++) begin
            vIn[k] = vS[k-1];
            dIn[k] = dS[k-1];
            tIn[k] = tS[k-1];
        end
    end

    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        alu_pipe_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (en[k]),
            .valid_i (vIn[k]),
            .data_i  (dIn[k]),
            .tag_i   (tIn[k]),
            .valid_o (vS[k]),
            .data_o  (dS[k]),
            .tag_o   (tS[k])
        );
    end

    // Outputs are forced to zero whenever nothing valid sits at the head.
    assign ready_o = en[0];
    assign valid_o = vS[LATENCY-1];
    assign f       = vS[LATENCY-1] ? dS[LATENCY-1] : '0;
    assign tag_o   = vS[LATENCY-1] ? tS[LATENCY-1] : '0;
    assign zero_o  = vS[LATENCY-1] && (dS[LATENCY-1] == '0);

endmodule : alu_pipe
